// File: rtl/parking_pkg.sv
// parking_pkg: shared one-hot state encoding and defaults for the parking lot gate controllers
package parking_pkg;
  localparam int ST_N = 7;
  typedef enum logic [ST_N-1:0] {
    S_IDLE = 7'b000_0001,
    S_WAIT = 7'b000_0010,
    S_BAD  = 7'b000_0100,
    S_ALM  = 7'b000_1000,
    S_CAR  = 7'b001_0000,
    S_BLK  = 7'b010_0000,
    S_CLS  = 7'b100_0000
  } state_e;
  localparam logic [7:0] DEF_EXIT_CODE = 8'd72;
  localparam int DEF_MAX_TRIES = 3;
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction
endpackage

// File: rtl/occupancy_counter.sv
// occupancy_counter: saturating up/down count of cars inside the lot with full/empty flags
module occupancy_counter #(
  parameter int CAPACITY = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  logic [CNT_W-1:0] count_q, count_d;
  // simultaneous inc and dec cancel; both directions clamp instead of wrapping
  always_comb begin
    count_d = (inc && !dec && count_q < CAP) ? count_q + CNT_W'(1) :
              (dec && !inc && count_q != '0) ? count_q - CNT_W'(1) : count_q;
  end
  // occupancy register, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end
  assign count = count_q;
  assign full  = (count_q == CAP);
  assign empty = (count_q == '0);
endmodule

// File: rtl/exit_controller_fsm.sv
// exit_controller_fsm: exit gate sequencing plus lot occupancy; EXIT_TIMEOUT_EN adds a code-entry timeout
module exit_controller_fsm
  import parking_pkg::*;
#(
  parameter int         CAPACITY  = 16,
  parameter int         CNT_W     = 5,
  parameter logic [7:0] EXIT_CODE = DEF_EXIT_CODE,
  parameter int         MAX_TRIES = DEF_MAX_TRIES
`ifdef EXIT_TIMEOUT_EN
  , parameter int       TIMEOUT_CYC = 256
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             entry_done,
  input  logic             senr_e,
  input  logic             senr_x,
  input  logic             ent_code,
  input  logic [7:0]       code,
  output logic             gate_o,
  output logic             gate_cls,
  output logic             alm_code,
  output logic             alm_blkg,
  output logic [CNT_W-1:0] occupancy,
  output logic             lot_full,
  output logic             lot_empty
);
  localparam logic [1:0] MAX_T = 2'(MAX_TRIES);
  state_e     state_q, state_d;
  logic [1:0] tries_q, tries_d;
  logic       code_ok;
  assign code_ok = ent_code && (code == EXIT_CODE);
`ifdef EXIT_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC);
  logic [TMR_W-1:0] tmr_q, tmr_d;
`endif
  // next-state and try counter; tries survive everything except reaching the open gate
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
`ifdef EXIT_TIMEOUT_EN
    tmr_d = tmr_q;
`endif
    case (state_q)
      S_IDLE: state_d = senr_e ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (ent_code) begin
          state_d = code_ok ? S_CAR : S_BAD;
          tries_d = code_ok ? 2'd0 : sat_inc2(tries_q);
        end
`ifdef EXIT_TIMEOUT_EN
        else if (tmr_q <= TMR_W'(1)) state_d = S_IDLE;
        tmr_d = ent_code ? TMR_LOAD : tmr_q - TMR_W'(1);
`endif
      end
      S_BAD: state_d = (tries_q == MAX_T) ? S_ALM : S_WAIT;
      S_ALM: begin
        state_d = code_ok ? S_CAR : S_ALM;
        tries_d = code_ok ? 2'd0 : tries_q;
      end
      S_CAR: state_d = (senr_e && senr_x) ? S_BLK : senr_x ? S_CLS : S_CAR;
      S_BLK: state_d = code_ok ? S_CLS : S_BLK;
      S_CLS: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef EXIT_TIMEOUT_EN
    if (state_d == S_WAIT && state_q != S_WAIT) tmr_d = TMR_LOAD;
`endif
  end
  // state, tries and optional timer registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tries_q <= 2'd0;
`ifdef EXIT_TIMEOUT_EN
      tmr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
`ifdef EXIT_TIMEOUT_EN
      tmr_q   <= tmr_d;
`endif
    end
  end
  assign gate_o   = (state_q == S_CAR) || (state_q == S_BLK);
  assign gate_cls = (state_q == S_CLS);
  assign alm_code = (state_q == S_ALM);
  assign alm_blkg = (state_q == S_BLK);
  occupancy_counter #(
    .CAPACITY(CAPACITY),
    .CNT_W   (CNT_W)
  ) u_occ (
    .clock(clock),
    .reset(reset),
    .inc  (entry_done),
    .dec  (gate_cls),
    .count(occupancy),
    .full (lot_full),
    .empty(lot_empty)
  );
endmodule
